fc_argmax_classifier: RTL and testbench
=======================================

Name: fc_argmax_classifier

Overview:
- Downstream consumer of the fully-connected output layer.
- Scans the numClasses signed 16-bit fixed-point output nodes, one per clock, to find the winning class index, its score, and the margin over the runner-up.
- Optionally writes a ReLU-clamped copy of the nodes.
- Uses the same enable/finished handshake as the other layer blocks, so it chains directly after the last FC stage.

Parameters:
- numClasses, 3, number of input nodes to classify (≥1; equals upstream numNodesOut).
- applyRelu, 1, when 1 the reluNodes outputs are max(x,0); when 0 they are copies of the inputs.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  start/run; normally tied to the upstream finished.
- inputNodes  input  16 x numClasses (unpacked array [0:numClasses-1])  signed scores; must be held stable while busy.
- reluNodes  output  16 x numClasses  registered ReLU/copy of each scanned node.
- classIdx  output  max(1,$clog2(numClasses))  index of the maximum score.
- maxScore  output  16  signed maximum score, unclamped by ReLU.
- margin  output  16  maxScore − secondScore, saturated to 0x7FFF; 0 when numClasses==1.
- finished  output  1  results valid.

Behaviour:
- Reset (async, active-high) clears all outputs and internal registers to 0 and forces state IDLE. This applies at any point, including mid-scan; partial results are discarded.
- States: IDLE, SCAN, DONE. Internal regs: idx, curMax, curSecond, curIdx.
- IDLE, enable=1 at an edge:
  - curMax ← in[0], curIdx ← 0, curSecond ← 0x8000 (most negative).
  - reluNodes[0] ← relu(in[0]); idx ← 1.
  - Next state: SCAN, or DONE if numClasses==1.
- SCAN, enable=1, one node per edge, x = in[idx]:
  - if x > curMax (strict signed compare): curSecond ← curMax, curMax ← x, curIdx ← idx.
  - else if x > curSecond: curSecond ← x.
  - reluNodes[idx] ← relu(x).
  - If idx==numClasses−1 go to DONE, else idx ← idx+1.
- SCAN, enable=0: hold all state (pause); resume on the next enable=1 without loss.
- Entering DONE (same edge as the last compare):
  - classIdx ← final curIdx, maxScore ← final curMax.
  - margin ← saturated 17-bit difference (final max − final second); 0 if numClasses==1.
  - finished ← 1.
- DONE, enable=1: hold outputs, finished stays 1.
- DONE, enable=0: go to IDLE, finished ← 0 on that edge. Result outputs keep their values until the next completion.
- Latency: the enable edge that leaves IDLE is edge 1; finished is high after edge numClasses. One scan costs numClasses cycles.
- Ties: the lowest index wins (strict >). An equal value still updates curSecond, so an exact tie gives margin=0.
- Margin arithmetic: sign-extend both operands to 17 bits and subtract. The result is always ≥0; if >32767, output 0x7FFF.
- relu(x) = x[15] ? 0 : x when applyRelu=1, else x.
- Outputs change only on clock edges (fully registered); no combinational path from inputNodes to outputs.

Test Plan:
- Basic, numClasses=3, in={0x0100,0x0300,0x0200}, enable held 1 → finished after edge 3; classIdx=1, maxScore=0x0300, margin=0x0100, reluNodes={0x0100,0x0300,0x0200}.
- Negatives and ReLU, in={0xFF00,0xFE00,0xFF80} (−256,−512,−128) → classIdx=2, maxScore=0xFF80, margin=0x0080, reluNodes all 0; with applyRelu=0, reluNodes equal the inputs.
- Tie and saturation:
  - in={0x0200,0x0200,0x0100} → classIdx=0, margin=0.
  - in={0x7FFF,0x8000,0x8000} → classIdx=0, margin=0x7FFF (saturated).
- Pause and restart: drop enable for 4 cycles after edge 2 → finished after 7 total cycles with the basic-case results. Then enable=0 → finished=0 next edge. Re-enable with new in={0x0005,0x0001,0x0009} → classIdx=2, margin=0x0004.
- Reset mid-scan: assert reset asynchronously between edges 1 and 2 → all outputs 0 immediately, state IDLE. A subsequent full run gives correct results. Also numClasses=1, in={0x1234} → finished after edge 1, classIdx=0, margin=0.

Source files
------------

// File: rtl/fc_argmax_classifier_if.sv
`default_nettype none
// ============================================================================
// Module   : fc_argmax_classifier_if
// Purpose  : Enable/finished handshake plus score and result buses for the
//            argmax classifier that follows the last fully-connected stage.
// Revision : 1.0  initial release
// ============================================================================
interface fc_argmax_classifier_if #(
  parameter int numClasses = 3
) ();
  localparam int IDX_W = (numClasses > 1) ? $clog2(numClasses) : 1;

  logic                    enable;
  logic signed [15:0]      inputNodes [0:numClasses-1];
  logic signed [15:0]      reluNodes  [0:numClasses-1];
  logic        [IDX_W-1:0] classIdx;
  logic signed [15:0]      maxScore;
  logic        [15:0]      margin;
  logic                    finished;

  // Upstream side drives the scores and the start strobe.
  modport master (
    output enable, inputNodes,
    input  reluNodes, classIdx, maxScore, margin, finished
  );

  // Classifier side.
  modport slave (
    input  enable, inputNodes,
    output reluNodes, classIdx, maxScore, margin, finished
  );
endinterface
`default_nettype wire

// File: rtl/fc_argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module   : fc_argmax_classifier
// Purpose  : Scans numClasses signed Q-format scores one per clock, reports the
//            winning index, its score and the saturated margin over the
//            runner-up, and writes a ReLU-clamped (or plain) copy of the scores.
// Revision : 1.0  initial release
// ============================================================================
module fc_argmax_classifier #(
  parameter int numClasses = 3,
  parameter int applyRelu  = 1
) (
  input  wire logic           clk,
  input  wire logic           reset,
  fc_argmax_classifier_if.slave bus
);
  localparam int IDX_W = (numClasses > 1) ? $clog2(numClasses) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numClasses - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic        [IDX_W-1:0] idx_q, idx_d;
  logic signed [15:0]      cur_max_q, cur_max_d;
  logic signed [15:0]      cur_second_q, cur_second_d;
  logic        [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic signed [15:0]      relu_q [0:numClasses-1];
  logic signed [15:0]      relu_d [0:numClasses-1];
  logic        [IDX_W-1:0] class_idx_q, class_idx_d;
  logic signed [15:0]      max_score_q, max_score_d;
  logic        [15:0]      margin_q, margin_d;
  logic                    finished_q, finished_d;

  function automatic logic signed [15:0] relu_f(input logic signed [15:0] x);
    if ((applyRelu != 0) && x[15]) return 16'sd0;
    return x;
  endfunction

  // Difference is never negative, so a 17-bit unsigned view is enough to detect overflow.
  function automatic logic [15:0] sat_margin(input logic signed [15:0] a,
                                             input logic signed [15:0] b);
    logic [16:0] diff;
    diff = {a[15], a} - {b[15], b};
    if (diff > 17'd32767) return 16'h7FFF;
    return diff[15:0];
  endfunction

  // Next-state and datapath: one compare per enabled edge, results latched on the last one.
  always_comb begin
    logic signed [15:0]      x;
    logic signed [15:0]      m;
    logic signed [15:0]      s;
    logic        [IDX_W-1:0] ci;

    state_d      = state_q;
    idx_d        = idx_q;
    cur_max_d    = cur_max_q;
    cur_second_d = cur_second_q;
    cur_idx_d    = cur_idx_q;
    relu_d       = relu_q;
    class_idx_d  = class_idx_q;
    max_score_d  = max_score_q;
    margin_d     = margin_q;
    finished_d   = finished_q;
    x            = 16'sd0;
    m            = cur_max_q;
    s            = cur_second_q;
    ci           = cur_idx_q;

    // Index select written as a compare loop so that odd class counts need no range checks.
    for (int i = 0; i < numClasses; i++) begin
      if (idx_q == IDX_W'(i)) x = bus.inputNodes[i];
    end

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          cur_max_d    = bus.inputNodes[0];
          cur_second_d = 16'sh8000;
          cur_idx_d    = '0;
          relu_d[0]    = relu_f(bus.inputNodes[0]);
          idx_d        = IDX_W'(1);
          if (numClasses == 1) begin
            state_d     = DONE;
            class_idx_d = '0;
            max_score_d = bus.inputNodes[0];
            margin_d    = 16'h0000;
            finished_d  = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        if (bus.enable) begin
          // Strict compare keeps the lowest index on ties; the tied value still becomes runner-up.
          if (x > cur_max_q) begin
            s  = cur_max_q;
            m  = x;
            ci = idx_q;
          end else if (x > cur_second_q) begin
            s = x;
          end
          cur_max_d    = m;
          cur_second_d = s;
          cur_idx_d    = ci;
          for (int i = 0; i < numClasses; i++) begin
            if (idx_q == IDX_W'(i)) relu_d[i] = relu_f(x);
          end
          if (idx_q == LAST_IDX) begin
            state_d     = DONE;
            class_idx_d = ci;
            max_score_d = m;
            margin_d    = sat_margin(m, s);
            finished_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      DONE: begin
        if (!bus.enable) begin
          state_d    = IDLE;
          finished_d = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        finished_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any scan in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cur_max_q    <= '0;
      cur_second_q <= '0;
      cur_idx_q    <= '0;
      for (int i = 0; i < numClasses; i++) relu_q[i] <= '0;
      class_idx_q  <= '0;
      max_score_q  <= '0;
      margin_q     <= '0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cur_max_q    <= cur_max_d;
      cur_second_q <= cur_second_d;
      cur_idx_q    <= cur_idx_d;
      relu_q       <= relu_d;
      class_idx_q  <= class_idx_d;
      max_score_q  <= max_score_d;
      margin_q     <= margin_d;
      finished_q   <= finished_d;
    end
  end

  generate
    for (genvar g = 0; g < numClasses; g++) begin : g_relu_out
      assign bus.reluNodes[g] = relu_q[g];
    end
  endgenerate

  assign bus.classIdx = class_idx_q;
  assign bus.maxScore = max_score_q;
  assign bus.margin   = margin_q;
  assign bus.finished = finished_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_argmax_classifier
// Purpose  : Self-checking bench for fc_argmax_classifier: directed cases,
//            randomized scans with pauses, async reset mid-scan, and a
//            single-class instance, all against a simple argmax model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fc_argmax_classifier;
  logic clk;
  logic reset;

  int checks;
  int errors;

  fc_argmax_classifier_if #(.numClasses(3)) bus3 ();
  fc_argmax_classifier_if #(.numClasses(3)) bus3n ();
  fc_argmax_classifier_if #(.numClasses(1)) bus1 ();

  fc_argmax_classifier #(.numClasses(3), .applyRelu(1)) dut (
    .clk(clk), .reset(reset), .bus(bus3)
  );
  fc_argmax_classifier #(.numClasses(3), .applyRelu(0)) dut_norelu (
    .clk(clk), .reset(reset), .bus(bus3n)
  );
  fc_argmax_classifier #(.numClasses(1), .applyRelu(1)) dut_one (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: winner is the first maximum; runner-up is the best of the rest.
  logic signed [15:0] vec [0:2];
  int exp_idx;
  int exp_max;
  int exp_margin;

  task automatic model3();
    int second;
    exp_idx = 0;
    for (int j = 1; j < 3; j++) if (int'(vec[j]) > int'(vec[exp_idx])) exp_idx = j;
    exp_max = int'(vec[exp_idx]);
    second  = -32768;
    for (int j = 0; j < 3; j++) if (j != exp_idx && int'(vec[j]) > second) second = int'(vec[j]);
    exp_margin = exp_max - second;
    if (exp_margin > 32767) exp_margin = 32767;
  endtask

  task automatic set_inputs(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    vec[0] = a; vec[1] = b; vec[2] = c;
    for (int i = 0; i < 3; i++) begin
      bus3.inputNodes[i]  = vec[i];
      bus3n.inputNodes[i] = vec[i];
    end
  endtask

  task automatic set_enable(input logic en);
    bus3.enable  = en;
    bus3n.enable = en;
  endtask

  // Starts from IDLE a little after an edge, runs one scan, checks results, returns to IDLE.
  task automatic run_case(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input int pause_len);
    int cycles;
    set_inputs(a, b, c);
    model3();
    set_enable(1'b1);
    cycles = 0;
    while (!bus3.finished && cycles < 60) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 2 && pause_len > 0) begin
        set_enable(1'b0);
        repeat (pause_len) @(posedge clk);
        #1;
        check({name, ".pause_hold"}, {31'd0, bus3.finished}, 32'd0);
        cycles += pause_len;
        set_enable(1'b1);
      end
    end
    check({name, ".latency"}, cycles, 3 + pause_len);
    check({name, ".finished_nr"}, {31'd0, bus3n.finished}, 32'd1);
    check({name, ".classIdx"}, {30'd0, bus3.classIdx}, exp_idx);
    check({name, ".maxScore"}, {16'd0, bus3.maxScore}, {16'd0, exp_max[15:0]});
    check({name, ".margin"}, {16'd0, bus3.margin}, {16'd0, exp_margin[15:0]});
    check({name, ".classIdx_nr"}, {30'd0, bus3n.classIdx}, exp_idx);
    check({name, ".margin_nr"}, {16'd0, bus3n.margin}, {16'd0, exp_margin[15:0]});
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.relu%0d", name, i), {16'd0, bus3.reluNodes[i]},
            {16'd0, (vec[i] < 0) ? 16'h0000 : vec[i]});
      check($sformatf("%s.copy%0d", name, i), {16'd0, bus3n.reluNodes[i]}, {16'd0, vec[i]});
    end
    // Holding enable keeps the result.
    @(posedge clk); #1;
    check({name, ".done_hold"}, {31'd0, bus3.finished}, 32'd1);
    // Dropping enable returns to IDLE; results stay.
    set_enable(1'b0);
    @(posedge clk); #1;
    check({name, ".finished_clear"}, {31'd0, bus3.finished}, 32'd0);
    check({name, ".idx_retained"}, {30'd0, bus3.classIdx}, exp_idx);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".finished"}, {31'd0, bus3.finished}, 32'd0);
    check({name, ".classIdx"}, {30'd0, bus3.classIdx}, 32'd0);
    check({name, ".maxScore"}, {16'd0, bus3.maxScore}, 32'd0);
    check({name, ".margin"}, {16'd0, bus3.margin}, 32'd0);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s.relu%0d", name, i), {16'd0, bus3.reluNodes[i]}, 32'd0);
  endtask

  function automatic logic [15:0] rand_score();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'($urandom_range(0, 3));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    set_enable(1'b0);
    set_inputs(16'h0, 16'h0, 16'h0);
    bus1.enable        = 1'b0;
    bus1.inputNodes[0] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    run_case("basic", 16'h0100, 16'h0300, 16'h0200, 0);
    run_case("neg",   16'hFF00, 16'hFE00, 16'hFF80, 0);
    run_case("tie",   16'h0200, 16'h0200, 16'h0100, 0);
    run_case("sat",   16'h7FFF, 16'h8000, 16'h8000, 0);
    run_case("pause", 16'h0100, 16'h0300, 16'h0200, 4);
    run_case("rerun", 16'h0005, 16'h0001, 16'h0009, 0);

    // Asynchronous reset between edge 1 and edge 2 of a scan.
    set_inputs(16'h0400, 16'h0100, 16'h0200);
    set_enable(1'b1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    set_enable(1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check({"midreset.idle"}, {31'd0, bus3.finished}, 32'd0);
    run_case("after_reset", 16'h0400, 16'h0100, 16'h0200, 0);

    // Randomized scans, some with pauses.
    for (int n = 0; n < 40; n++) begin
      run_case($sformatf("rnd%0d", n), rand_score(), rand_score(), rand_score(),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
    end

    // Single-class instance finishes on the first enabled edge.
    for (int n = 0; n < 4; n++) begin
      logic [15:0] v;
      v = (n == 0) ? 16'h1234 : rand_score();
      bus1.inputNodes[0] = v;
      bus1.enable = 1'b1;
      @(posedge clk); #1;
      check("one.finished", {31'd0, bus1.finished}, 32'd1);
      check("one.classIdx", {31'd0, bus1.classIdx}, 32'd0);
      check("one.maxScore", {16'd0, bus1.maxScore}, {16'd0, v});
      check("one.margin",   {16'd0, bus1.margin}, 32'd0);
      check("one.relu",     {16'd0, bus1.reluNodes[0]}, {16'd0, v[15] ? 16'h0000 : v});
      bus1.enable = 1'b0;
      @(posedge clk); #1;
      check("one.clear", {31'd0, bus1.finished}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
